flash_decoder: RTL and testbench

FLASH_DECODER -- requirements
Module: flash_decoder

---
 rtl/flash_pkg.sv | 17 +
 rtl/flash_bubble_fix.sv | 26 ++
 rtl/flash_decoder.sv | 159 +++++++++++++++
 tb/tb_flash_decoder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/flash_pkg.sv
// Shared definitions for the flash ADC thermometer decoder: default comparator
// count, output code width helper and the calibration-gating FSM states.
package flash_pkg;

    localparam int N_CMP_DEF = 32;

    typedef enum logic [1:0] {
        ST_WAIT_CAL = 2'd0,
        ST_SETTLE   = 2'd1,
        ST_RUN      = 2'd2
    } flash_state_t;

    function automatic int code_w(input int n_cmp);
        return $clog2(n_cmp + 1);
    endfunction

endpackage

// File: rtl/flash_bubble_fix.sv
// Combinational bubble suppression: three-input majority vote across each
// thermometer bit and its neighbours, plus a flag when any bit was changed.
module flash_bubble_fix
    import flash_pkg::*;
#(
    parameter int N_CMP = N_CMP_DEF
) (
    input  logic [N_CMP-1:0] t,
    output logic [N_CMP-1:0] t_fix,
    output logic             mismatch
);

    // Virtual comparator below the lowest threshold always fires, the one above
    // the highest never does.
    logic [N_CMP+1:0] ext;

    always_comb begin
        ext   = {1'b0, t, 1'b1};
        t_fix = '0;
        for (int i = 0; i < N_CMP; i++) begin
            t_fix[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
        end
        mismatch = (t_fix != t);
    end

endmodule

// File: rtl/flash_decoder.sv
// Flash ADC thermometer-to-binary decoder: waits for a settled calibration flag,
// then captures, bubble-corrects and popcounts comparator samples in 3 stages.
module flash_decoder
    import flash_pkg::*;
#(
    parameter  int N_CMP      = N_CMP_DEF,
    parameter  int CAL_SETTLE = 4,
    parameter  int ERR_W      = 16,
    localparam int CODE_W     = code_w(N_CMP)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CMP-1:0]  Q,
    input  logic              rdy_cal,
    input  logic              sample_en,
    input  logic              err_clr,
    output logic [CODE_W-1:0] code,
    output logic              code_vld,
    output logic              ovr,
    output logic              udr,
    output logic              bubble,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              running
);

    localparam int CNT_W = (CAL_SETTLE < 2) ? 1 : $clog2(CAL_SETTLE + 1);

    function automatic logic [CODE_W-1:0] popcount(input logic [N_CMP-1:0] t);
        logic [CODE_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < N_CMP; i++) begin
            acc = acc + CODE_W'(t[i]);
        end
        return acc;
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    flash_state_t      state_q;
    logic [CNT_W-1:0]  settle_cnt;

    logic              vld_p0;
    logic              vld_p1;
    logic [N_CMP-1:0]  q_p0;
    logic [N_CMP-1:0]  t_p1;
    logic              bub_p1;

    logic [N_CMP-1:0]  t_fix;
    logic              fix_err;
    logic [CODE_W-1:0] cnt_p1;
    logic              cap;
    logic              drop;
    logic              emit;

    // Losing calibration while running flushes every in-flight sample, including
    // the one that would otherwise reach the outputs on this same edge.
    assign drop   = (state_q == ST_RUN) && !rdy_cal;
    assign cap    = (state_q == ST_RUN) && rdy_cal && sample_en;
    assign emit   = vld_p1 && !drop;
    assign cnt_p1 = popcount(t_p1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_WAIT_CAL;
            settle_cnt <= '0;
            running    <= 1'b0;
        end else begin
            case (state_q)
                ST_WAIT_CAL: begin
                    if (rdy_cal) begin
                        settle_cnt <= CNT_W'(1);
                        if (CAL_SETTLE <= 1) begin
                            state_q <= ST_RUN;
                            running <= 1'b1;
                        end else begin
                            state_q <= ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (!rdy_cal) begin
                        state_q    <= ST_WAIT_CAL;
                        settle_cnt <= '0;
                    end else if (settle_cnt == CNT_W'(CAL_SETTLE - 1)) begin
                        state_q    <= ST_RUN;
                        settle_cnt <= CNT_W'(CAL_SETTLE);
                        running    <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!rdy_cal) begin
                        state_q    <= ST_WAIT_CAL;
                        settle_cnt <= '0;
                        running    <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= ST_WAIT_CAL;
                    settle_cnt <= '0;
                    running    <= 1'b0;
                end
            endcase
        end
    end

    flash_bubble_fix #(
        .N_CMP (N_CMP)
    ) u_bubble_fix (
        .t        (q_p0),
        .t_fix    (t_fix),
        .mismatch (fix_err)
    );

    always_ff @(posedge clk) begin
        // p0: raw comparator capture
        if (cap) begin
            q_p0 <= Q;
        end
        // p1: bubble-corrected thermometer
        if (vld_p0) begin
            t_p1   <= t_fix;
            bub_p1 <= fix_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0   <= 1'b0;
            vld_p1   <= 1'b0;
            code_vld <= 1'b0;
            code     <= '0;
            ovr      <= 1'b0;
            udr      <= 1'b0;
            bubble   <= 1'b0;
            err_cnt  <= '0;
        end else begin
            vld_p0   <= cap;
            vld_p1   <= vld_p0 && !drop;
            // p2: binary code and range flags
            code_vld <= emit;
            if (emit) begin
                code   <= cnt_p1;
                ovr    <= (cnt_p1 == CODE_W'(N_CMP));
                udr    <= (cnt_p1 == '0);
                bubble <= bub_p1;
            end
            if (err_clr) begin
                err_cnt <= '0;
            end else if (emit && bub_p1) begin
                err_cnt <= sat_inc(err_cnt);
            end
        end
    end

endmodule

// File: tb/tb_flash_decoder.sv
// Self-checking bench for flash_decoder: directed scenarios plus a random stream,
// compared each cycle against a queue-based behavioural model.
module tb_flash_decoder;

    localparam int CAL_SETTLE = 4;

    logic        clk;
    logic        rst;
    logic [31:0] Q;
    logic        rdy_cal;
    logic        sample_en;
    logic        err_clr;

    logic [5:0]  code,   code_4;
    logic        code_vld, code_vld_4;
    logic        ovr,    ovr_4;
    logic        udr,    udr_4;
    logic        bubble, bubble_4;
    logic [15:0] err_cnt;
    logic [3:0]  err_cnt_4;
    logic        running, running_4;

    flash_decoder #(.N_CMP(32), .CAL_SETTLE(CAL_SETTLE), .ERR_W(16)) dut (
        .clk(clk), .rst(rst), .Q(Q), .rdy_cal(rdy_cal), .sample_en(sample_en),
        .err_clr(err_clr), .code(code), .code_vld(code_vld), .ovr(ovr), .udr(udr),
        .bubble(bubble), .err_cnt(err_cnt), .running(running)
    );

    flash_decoder #(.N_CMP(32), .CAL_SETTLE(CAL_SETTLE), .ERR_W(4)) dut4 (
        .clk(clk), .rst(rst), .Q(Q), .rdy_cal(rdy_cal), .sample_en(sample_en),
        .err_clr(err_clr), .code(code_4), .code_vld(code_vld_4), .ovr(ovr_4), .udr(udr_4),
        .bubble(bubble_4), .err_cnt(err_cnt_4), .running(running_4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] q;
    } ent_t;

    ent_t        pq[$];
    int          cyc;
    int          streak;
    bit          run_m;
    bit          exp_vld;
    int          exp_code;
    bit          exp_ovr, exp_udr, exp_bub;
    int          e16, e4;
    int          total, passed, failed;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            failed = failed + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Spec-level conversion: neighbour-majority correction then count of ones.
    task automatic ref_conv(input logic [31:0] q, output int c, output bit b);
        logic [33:0] ext;
        logic [31:0] f;
        int          ones;
        ext = {1'b0, q, 1'b1};
        c = 0;
        for (int i = 0; i < 32; i++) begin
            ones = int'(ext[i]) + int'(ext[i+1]) + int'(ext[i+2]);
            f[i] = (ones >= 2);
            c += int'(f[i]);
        end
        b = (f != q);
    endtask

    task automatic tick();
        ent_t e;
        int   c;
        bit   b;
        bit   was_run;
        bit   emit;
        @(posedge clk);
        cyc++;
        if (rst) begin
            pq.delete();
            streak = 0; run_m = 0; exp_vld = 0;
            exp_code = 0; exp_ovr = 0; exp_udr = 0; exp_bub = 0;
            e16 = 0; e4 = 0;
        end else begin
            was_run = run_m;
            emit    = 0;
            if (was_run && !rdy_cal) begin
                pq.delete();
            end else if (pq.size() > 0 && pq[0].due == cyc) begin
                e = pq.pop_front();
                emit = 1;
                ref_conv(e.q, c, b);
                exp_code = c; exp_ovr = (c == 32); exp_udr = (c == 0); exp_bub = b;
            end
            exp_vld = emit;
            if (err_clr) begin
                e16 = 0; e4 = 0;
            end else if (emit && exp_bub) begin
                if (e16 < 65535) e16++;
                if (e4 < 15) e4++;
            end
            if (was_run && rdy_cal && sample_en) pq.push_back('{cyc + 2, Q});
            streak = rdy_cal ? streak + 1 : 0;
            run_m  = (streak >= CAL_SETTLE);
        end
        #1;
        chk("running",  running,  run_m);
        chk("code_vld", code_vld, exp_vld);
        chk("code",     code,     exp_code);
        chk("ovr",      ovr,      exp_ovr);
        chk("udr",      udr,      exp_udr);
        chk("bubble",   bubble,   exp_bub);
        chk("err_cnt",  err_cnt,  e16);
        chk("vld_w4",   code_vld_4, exp_vld);
        chk("err_w4",   err_cnt_4,  e4);
    endtask

    task automatic run_one(input logic [31:0] q);
        Q = q; sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        tick();
        tick();
    endtask

    function automatic logic [31:0] gen_q();
        logic [63:0] one;
        logic [31:0] q;
        int          lvl;
        one = 64'd1;
        lvl = $urandom_range(0, 32);
        q = 32'((one << lvl) - 64'd1);
        if ($urandom_range(0, 2) == 0) q[$urandom_range(0, 31)] ^= 1'b1;
        if ($urandom_range(0, 5) == 0) q[$urandom_range(0, 31)] ^= 1'b1;
        return q;
    endfunction

    initial begin
        total = 0; passed = 0; failed = 0; cyc = 0;
        streak = 0; run_m = 0; exp_vld = 0;
        exp_code = 0; exp_ovr = 0; exp_udr = 0; exp_bub = 0; e16 = 0; e4 = 0;
        rst = 1'b1; Q = '0; rdy_cal = 1'b0; sample_en = 1'b0; err_clr = 1'b0;
        #1;
        tick(); tick();
        chk("rst_code", code, 0);
        chk("rst_running", running, 0);

        // Calibration flag too short, then long enough
        rst = 1'b0; rdy_cal = 1'b1; sample_en = 1'b1; Q = 32'hFFFF_FFFF;
        repeat (3) tick();
        rdy_cal = 1'b0;
        tick();
        chk("settle3_running", running, 0);
        sample_en = 1'b0; rdy_cal = 1'b1;
        repeat (3) tick();
        chk("settle_pre_running", running, 0);
        tick();
        chk("settle4_running", running, 1);

        run_one(32'h0000_FFFF);
        chk("half_vld", code_vld, 1);
        chk("half_code", code, 16);
        chk("half_bubble", bubble, 0);
        tick();
        chk("half_vld_off", code_vld, 0);
        chk("half_hold", code, 16);

        run_one(32'hFFFF_FFFF);
        chk("full_code", code, 32);
        chk("full_ovr", ovr, 1);
        run_one(32'h0000_0000);
        chk("zero_code", code, 0);
        chk("zero_udr", udr, 1);

        run_one(32'h0000_FFBF);
        chk("hole_code", code, 16);
        chk("hole_bubble", bubble, 1);
        chk("hole_err", err_cnt, 1);
        Q = 32'h0000_FFBF; sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_wins_vld", code_vld, 1);
        chk("clr_wins_err", err_cnt, 0);

        // Back-to-back samples with calibration lost after the second
        sample_en = 1'b1;
        Q = gen_q(); tick();
        Q = gen_q(); tick();
        rdy_cal = 1'b0;
        repeat (3) begin Q = gen_q(); tick(); chk("drop_no_vld", code_vld, 0); end
        sample_en = 1'b0;
        repeat (3) begin tick(); chk("drop_no_vld_tail", code_vld, 0); end
        chk("drop_running", running, 0);

        // Random stream with occasional calibration loss, clears and resets
        rdy_cal = 1'b1;
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            rdy_cal   = ($urandom_range(0, 39) != 0);
            sample_en = ($urandom_range(0, 2) != 0);
            err_clr   = ($urandom_range(0, 29) == 0);
            Q         = gen_q();
            tick();
        end

        // Saturation of the narrow error counter
        rst = 1'b0; rdy_cal = 1'b1; sample_en = 1'b0; err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        repeat (5) tick();
        Q = 32'h0000_FFBF; sample_en = 1'b1;
        repeat (20) tick();
        sample_en = 1'b0;
        repeat (3) tick();
        chk("sat_err4", err_cnt_4, 15);
        chk("sat_err16", err_cnt, 20);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
